// File: rtl/day1_stream_sequencer_if.sv
// rtl/day1_stream_sequencer_if.sv - ASCII byte stream handshake bundle for the day-1 sequencer
interface day1_stream_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/day1_stream_sequencer.sv
// rtl/day1_stream_sequencer.sv - ASCII line parser driving the day-1 accumulator strobe; optional stats via DAY1_SEQ_STATS_EN
module day1_stream_sequencer #(
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  day1_stream_sequencer_if.slave in_if,
  output logic [DATA_W-1:0]     par_input,
  output logic                  next_val,
  output logic                  busy,
  output logic                  done,
  output logic                  err_char,
  output logic                  err_ovf,
  output logic [CNT_W-1:0]      value_count,
  output logic [CNT_W-1:0]      group_count
);

  typedef enum logic [2:0] {IDLE, PARSE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam int PH_W = 16;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              digit_seen;
  logic              last_nonzero;
  logic              eof_pending;
  logic              ready_q;
  logic [PH_W-1:0]   phase;

  logic              start_ok;
  logic              accept;
  logic              is_digit;
  logic [DATA_W+3:0] wide_val;
  logic              ovf;
  logic              line_end;
  logic              flush;
  logic              eof_idle;
  logic              emit_req;
  logic [DATA_W-1:0] emit_val;
  logic              go_done;

  assign in_if.in_ready = ready_q;

  // Decode the current byte and decide whether this PARSE cycle emits, and what
  always_comb begin
    start_ok = start && ((state == IDLE) || (state == DONE));
    accept   = (state == PARSE) && ready_q && in_if.in_valid;
    is_digit = (in_if.in_data >= 8'h30) && (in_if.in_data <= 8'h39);
    wide_val = {4'b0000, acc} * (DATA_W+4)'(10) + {{DATA_W{1'b0}}, in_if.in_data[3:0]};
    ovf      = |wide_val[DATA_W+3:DATA_W];
    line_end = accept && (in_if.in_data == 8'h0A);
    // Stream ended with digits still pending: treat as an implicit line feed.
    flush    = (state == PARSE) && eof_pending && digit_seen;
    eof_idle = (state == PARSE) && eof_pending && !digit_seen;
    emit_req = 1'b0;
    emit_val = '0;
    go_done  = 1'b0;
    if ((line_end || flush) && digit_seen && (acc != '0)) begin
      emit_req = 1'b1;
      emit_val = acc;
    end else if (((line_end && !digit_seen) || eof_idle) && last_nonzero) begin
      // Separators only follow a value, so runs of blank lines collapse to one.
      emit_req = 1'b1;
      emit_val = '0;
    end
    go_done = eof_idle && !last_nonzero;
  end

  // Main control FSM: parse bytes, then run the setup/strobe/hold emit sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      par_input    <= '0;
      next_val     <= 1'b0;
      ready_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_char     <= 1'b0;
      err_ovf      <= 1'b0;
      acc          <= '0;
      digit_seen   <= 1'b0;
      last_nonzero <= 1'b0;
      eof_pending  <= 1'b0;
      phase        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state        <= PARSE;
            ready_q      <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_char     <= 1'b0;
            err_ovf      <= 1'b0;
            acc          <= '0;
            digit_seen   <= 1'b0;
            last_nonzero <= 1'b0;
            eof_pending  <= 1'b0;
          end
        end
        PARSE: begin
          if (accept) begin
            if (in_if.in_last) begin
              eof_pending <= 1'b1;
              ready_q     <= 1'b0;
            end
            if (is_digit) begin
              acc        <= ovf ? '1 : wide_val[DATA_W-1:0];
              digit_seen <= 1'b1;
              if (ovf) err_ovf <= 1'b1;
            end else if (in_if.in_data == 8'h0A) begin
              if (digit_seen && (acc == '0)) err_char <= 1'b1;
              acc        <= '0;
              digit_seen <= 1'b0;
            end else if (in_if.in_data != 8'h0D) begin
              err_char <= 1'b1;
            end
          end
          if (flush) begin
            if (acc == '0) err_char <= 1'b1;
            acc        <= '0;
            digit_seen <= 1'b0;
          end
          if (emit_req) begin
            par_input    <= emit_val;
            last_nonzero <= (emit_val != '0);
            ready_q      <= 1'b0;
            phase        <= '0;
            state        <= SETUP;
          end else if (go_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        SETUP: begin
          if (phase == PH_W'(SETUP_CYCLES - 1)) begin
            phase    <= '0;
            next_val <= 1'b1;
            state    <= STROBE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        STROBE: begin
          if (phase == PH_W'(STROBE_CYCLES - 1)) begin
            phase    <= '0;
            next_val <= 1'b0;
            state    <= HOLD;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        HOLD: begin
          state   <= PARSE;
          ready_q <= !eof_pending;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAY1_SEQ_STATS_EN
  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] group_q;

  // Count emitted values and separators for the current run
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      value_q <= '0;
      group_q <= '0;
    end else if (emit_req) begin
      if (emit_val != '0) value_q <= value_q + CNT_W'(1);
      else                group_q <= group_q + CNT_W'(1);
    end
  end

  assign value_count = value_q;
  assign group_count = group_q;
`else
  assign value_count = '0;
  assign group_count = '0;
`endif

endmodule

// File: tb/tb_day1_stream_sequencer.sv
// tb/tb_day1_stream_sequencer.sv - directed self-checking bench for day1_stream_sequencer
module tb_day1_stream_sequencer;

`ifdef DAY1_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] par_input;
  logic        next_val;
  logic        busy;
  logic        done;
  logic        err_char;
  logic        err_ovf;
  logic [15:0] value_count;
  logic [15:0] group_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] emits[$];
  logic [31:0] exp_q[$];
  logic        nv_prev = 1'b0;

  day1_stream_sequencer_if sif();

  day1_stream_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_if(sif.slave),
    .par_input(par_input), .next_val(next_val), .busy(busy), .done(done),
    .err_char(err_char), .err_ovf(err_ovf),
    .value_count(value_count), .group_count(group_count)
  );

  always #5 clk = ~clk;

  // Capture par_input on every rising edge of next_val
  always @(negedge clk) begin
    if (next_val && !nv_prev) emits.push_back(par_input);
    nv_prev <= next_val;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    sif.in_data  = b;
    sif.in_valid = 1'b1;
    sif.in_last  = last;
    while (sif.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", sif.in_ready, 1);
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic start_run();
    emits.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, sif.in_ready, 0);
  endtask

  task automatic check_emits(input string tag);
    int n;
    check({tag, "_nemit"}, emits.size(), exp_q.size());
    n = (emits.size() < exp_q.size()) ? emits.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_emit%0d", tag, i), emits[i], exp_q[i]);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    sif.in_data  = 8'h00;
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_next_val", next_val, 0);
    check("rst_par_input", par_input, 0);
    check("rst_ready", sif.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_char, err_ovf}, 0);
    check("rst_counts", {value_count, group_count}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic grouped stream
    start_run();
    send_str("1000\n2000\n\n3000", 1'b1);
    wait_done("basic");
    exp_q = '{32'd1000, 32'd2000, 32'd0, 32'd3000, 32'd0};
    check_emits("basic");
    check("basic_errs", {err_char, err_ovf}, 0);
    check("basic_vcnt", value_count, STATS ? 16'd3 : 16'd0);
    check("basic_gcnt", group_count, STATS ? 16'd2 : 16'd0);

    // Emit latency and par_input stability around the strobe
    start_run();
    send_byte("7", 1'b0);
    send_byte(8'h0A, 1'b0);
    check("lat1_nv", next_val, 0);
    check("lat1_par", par_input, 7);
    check("lat1_ready", sif.in_ready, 0);
    @(posedge clk); #1;
    check("lat2_nv", next_val, 1);
    check("lat2_par", par_input, 7);
    @(posedge clk); #1;
    check("lat3_nv", next_val, 0);
    check("lat3_par", par_input, 7);
    check("lat3_ready", sif.in_ready, 0);
    @(posedge clk); #1;
    check("lat4_ready", sif.in_ready, 1);
    check("lat4_busy", busy, 1);
    send_byte(8'h0A, 1'b1);
    wait_done("lat");
    exp_q = '{32'd7, 32'd0};
    check_emits("lat");

    // Blank line collapse
    start_run();
    send_str("5\n\n\n\n7\n", 1'b1);
    wait_done("blank");
    exp_q = '{32'd5, 32'd0, 32'd7, 32'd0};
    check_emits("blank");
    check("blank_vcnt", value_count, STATS ? 16'd2 : 16'd0);
    check("blank_gcnt", group_count, STATS ? 16'd2 : 16'd0);

    // Overflow saturation
    start_run();
    send_str("4294967296\n", 1'b1);
    wait_done("ovf");
    exp_q = '{32'hFFFF_FFFF, 32'd0};
    check_emits("ovf");
    check("ovf_err_ovf", err_ovf, 1);
    check("ovf_err_char", err_char, 0);

    // Unsupported character skipped; errors cleared by start
    start_run();
    send_str("12a3\n", 1'b1);
    wait_done("badch");
    exp_q = '{32'd123, 32'd0};
    check_emits("badch");
    check("badch_err_char", err_char, 1);
    check("badch_err_ovf", err_ovf, 0);

    // Zero-valued line discarded
    start_run();
    send_str("0\n", 1'b1);
    wait_done("zero");
    exp_q = {};
    check_emits("zero");
    check("zero_err_char", err_char, 1);

    // CRLF line endings
    start_run();
    send_str("1\r\n2\r\n", 1'b1);
    wait_done("crlf");
    exp_q = '{32'd1, 32'd2, 32'd0};
    check_emits("crlf");
    check("crlf_err_char", err_char, 0);

    // Empty stream
    start_run();
    send_byte(8'h0A, 1'b1);
    wait_done("empty");
    exp_q = {};
    check_emits("empty");

    // Reset during STROBE, then a clean run
    start_run();
    send_byte("8", 1'b0);
    send_byte(8'h0A, 1'b0);
    @(posedge clk); #1;
    check("mid_nv_high", next_val, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_nv_low", next_val, 0);
    check("mid_ready", sif.in_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    start_run();
    send_str("9\n", 1'b1);
    wait_done("post");
    exp_q = '{32'd9, 32'd0};
    check_emits("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
